matrix_result_reader: RTL and testbench
=======================================

# matrix_result_reader

Result-side companion to the 3x3 matrix multiplier. It watches the multiplier's `done` level and captures the nine 18-bit results C0..C8 on its rising edge. It then streams them out as 27 bytes over an 8-bit valid/ready byte interface toward the chip's output pins. It decouples the multiplier's one-cycle parallel result from a slow, back-pressured byte sink.

## Interface
- `ELEM_W`, 18: result element width; fixed at 18, zero-extended to 24 bits for transmission.
- `NUM_ELEM`, 9: elements per frame; fixed at 9 (C0..C8).
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `done_in`  in  1  multiplier `done` level; frame capture on its 0->1 transition.
- `C0`..`C8`  in  18 each  multiplier results, row-major (C0 = row0/col0, C8 = row2/col2).
- `out_data`  out  8  current byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink accepts byte when `out_valid && out_ready`.
- `out_last`  out  1  high with the final (27th) byte of a frame.
- `busy`  out  1  frame being transmitted (state SEND).
- `frame_done`  out  1  one-cycle pulse after the final byte is accepted.
- `overrun`  out  1  sticky; a new frame arrived while busy and was dropped.
- `clear_overrun`  in  1  synchronous clear of `overrun`.

## Operation
- `done_d` is a 1-bit register of `done_in`; rise = `done_in && !done_d`. After reset `done_d`=0, so `done_in` already high at reset release counts as a rise.
- States: IDLE, SEND.
- IDLE:
  - On rise: latch C0..C8 into shadow registers, set elem_idx=0 and byte_idx=0, and go to SEND.
  - Otherwise stay in IDLE.
- SEND:
  - `out_valid`=1 and `out_data` = selected byte of shadow[elem_idx].
  - Byte order per element, little-endian: byte0=C[7:0], byte1=C[15:8], byte2={6'b0,C[17:16]}.
  - Elements are sent C0 through C8: 27 bytes per frame.
- Handshake (`out_valid && out_ready`):
  - byte_idx goes 0->1->2. At 2 it wraps to 0 and elem_idx increments.
  - On the handshake at elem_idx=8, byte_idx=2, the frame ends: next state IDLE and `frame_done`=1 in the next cycle.
- Rise while in SEND, not on the final handshake: the frame is ignored, shadow registers are unchanged, the stream continues, and `overrun` is set.
- Rise on the same cycle as the final handshake: the new frame is captured, the state stays SEND with indices 0, `frame_done` still pulses, and `overrun` is not set.
- `overrun` clears on `clear_overrun`. If set and clear occur in the same cycle, set wins.
- `out_last` = `out_valid` && elem_idx==8 && byte_idx==2.
- `out_data`=0 whenever `out_valid`=0.
- `busy` = (state==SEND).
- `done_in` held high emits exactly one frame. A new frame needs `done_in` to fall and rise again.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `frame_done`=0, `overrun`=0. Also shadow registers, indices, `done_d` and state (IDLE) are reset.
- Reset mid-frame aborts immediately (asynchronous). There is no partial-frame resumption.
- Latency: rise sampled at edge N gives `out_valid`=1 with byte0 of C0 during cycle N+1.
- With `out_ready` held high, one byte is accepted per cycle: bytes in cycles N+1..N+27 and `frame_done` in cycle N+28.
- `out_data`, `out_valid` and `out_last` are driven from registered state only. There is no combinational path from `out_ready`.
- They hold stable while `out_valid && !out_ready`.
- Capture is from the C inputs as sampled at the rise edge. The multiplier updates C and `done` on the same edge, so C is valid when `done_in` is first seen high.

## Test plan
- Basic frame: C0=0x3FFFF, C1=0x12345, C2..C8=0, `out_ready`=1, pulse `done_in`.
  - Bytes are FF FF 03 45 23 01 followed by 21 zero bytes.
  - `out_last` is high only on byte 27.
  - `frame_done` is high in the cycle after byte 27.
  - `busy` is high for exactly 27 cycles.
- Backpressure: random `out_ready` at 30% duty with C_i = 0x10000+i. The byte sequence matches the basic-frame encoding, and `out_data` and `out_last` never change while valid is high and ready is low.
- Overrun: second `done_in` rise with new C values at byte 10.
  - The stream finishes with the original values and `overrun` goes to 1.
  - `clear_overrun` brings it to 0 in the next cycle.
  - `clear_overrun` in the same cycle as a new overrun leaves it at 1.
- Back-to-back: rise coincident with the final handshake. Then 54 consecutive bytes (frame A, then frame B), `frame_done` pulses twice, and `overrun` stays 0.
- Reset mid-stream: assert `reset` at byte 5. All outputs are 0 immediately, and after release the block stays IDLE until the next rise.
- Level hold: `done_in` held high for 100 cycles produces exactly one frame. A fall then rise produces a second frame.

Source files
------------

// File: rtl/matrix_result_reader_if.sv
// ---------------------------------------------------------------------------
// matrix_result_reader_if
//
// Byte-wide valid/ready stream carrying matrix results toward the output pins.
//
// Signals:
//   out_data   8-bit byte currently offered by the source
//   out_valid  out_data holds a valid byte
//   out_ready  sink accepts the byte when out_valid && out_ready
//   out_last   marks the final byte of a frame
//
// Modports:
//   master  byte source (drives data/valid/last, samples ready)
//   slave   byte sink   (samples data/valid/last, drives ready)
// ---------------------------------------------------------------------------
interface matrix_result_reader_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/matrix_result_reader.sv
// ---------------------------------------------------------------------------
// matrix_result_reader
//
// Result-side companion to the 3x3 matrix multiplier. On the rising edge of
// the multiplier's done level, the nine results C0..C8 are latched into
// shadow registers and then streamed out as 27 bytes (three little-endian
// bytes per zero-extended element, C0 first) over a back-pressured byte
// stream. A frame that arrives while a stream is in progress is dropped and
// flagged with the sticky overrun bit.
//
// Ports:
//   clk            single clock, all state on the rising edge
//   reset          asynchronous, active-low reset
//   done_in        multiplier done level; a 0->1 transition starts a frame
//   C0..C8         multiplier results, row-major
//   out_if         byte stream (master side): out_data/out_valid/out_last
//                  driven, out_ready sampled
//   clear_overrun  synchronous clear of overrun
//   busy           high while a frame is being transmitted
//   frame_done     one-cycle pulse after the final byte is accepted
//   overrun        sticky, a frame arrived while busy and was dropped
// ---------------------------------------------------------------------------
module matrix_result_reader #(
  parameter int ELEM_W   = 18,
  parameter int NUM_ELEM = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   done_in,
  input  logic [ELEM_W-1:0]      C0,
  input  logic [ELEM_W-1:0]      C1,
  input  logic [ELEM_W-1:0]      C2,
  input  logic [ELEM_W-1:0]      C3,
  input  logic [ELEM_W-1:0]      C4,
  input  logic [ELEM_W-1:0]      C5,
  input  logic [ELEM_W-1:0]      C6,
  input  logic [ELEM_W-1:0]      C7,
  input  logic [ELEM_W-1:0]      C8,
  matrix_result_reader_if.master out_if,
  input  logic                   clear_overrun,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);

  localparam int TX_W = 24;
  localparam logic [3:0] LAST_ELEM = 4'(NUM_ELEM - 1);
  localparam logic [1:0] LAST_BYTE = 2'd2;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            state_q, state_d;
  logic              doneD_q;
  logic [ELEM_W-1:0] shadow_q [NUM_ELEM];
  logic [3:0]        elemIdx_q, elemIdx_d;
  logic [1:0]        byteIdx_q, byteIdx_d;
  logic              frameDone_q, frameDone_d;
  logic              overrun_q, overrun_d;

  logic [ELEM_W-1:0] cIn [NUM_ELEM];
  logic              capture;
  logic              rise;
  logic              sending;
  logic              handshake;
  logic              lastByte;
  logic [TX_W-1:0]   curElem;

  assign cIn[0] = C0;
  assign cIn[1] = C1;
  assign cIn[2] = C2;
  assign cIn[3] = C3;
  assign cIn[4] = C4;
  assign cIn[5] = C5;
  assign cIn[6] = C6;
  assign cIn[7] = C7;
  assign cIn[8] = C8;

  // The done level is edge-detected against its registered copy; since the
  // copy resets to 0, done_in already high at reset release counts as a rise.
  assign rise      = done_in && !doneD_q;
  assign sending   = (state_q == SEND);
  assign handshake = sending && out_if.out_ready;
  assign lastByte  = (elemIdx_q == LAST_ELEM) && (byteIdx_q == LAST_BYTE);
  assign curElem   = {{(TX_W-ELEM_W){1'b0}}, shadow_q[elemIdx_q]};

  // State register: FSM state, stream indices, shadow copy of the results
  // and the registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      doneD_q     <= 1'b0;
      elemIdx_q   <= 4'd0;
      byteIdx_q   <= 2'd0;
      frameDone_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_ELEM; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      doneD_q     <= done_in;
      elemIdx_q   <= elemIdx_d;
      byteIdx_q   <= byteIdx_d;
      frameDone_q <= frameDone_d;
      overrun_q   <= overrun_d;
      if (capture) begin
        for (int i = 0; i < NUM_ELEM; i++) begin
          shadow_q[i] <= cIn[i];
        end
      end
    end
  end

  // Next-state logic. A rise landing on the final handshake is not an
  // overrun: the old frame is complete, so the new one is captured and the
  // stream restarts from index 0 without passing through IDLE.
  always_comb begin
    state_d     = state_q;
    elemIdx_d   = elemIdx_q;
    byteIdx_d   = byteIdx_q;
    frameDone_d = 1'b0;
    capture     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          capture   = 1'b1;
          elemIdx_d = 4'd0;
          byteIdx_d = 2'd0;
          state_d   = SEND;
        end
      end

      SEND: begin
        if (handshake) begin
          if (lastByte) begin
            frameDone_d = 1'b1;
            elemIdx_d   = 4'd0;
            byteIdx_d   = 2'd0;
            if (rise) begin
              capture = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else if (byteIdx_q == LAST_BYTE) begin
            byteIdx_d = 2'd0;
            elemIdx_d = elemIdx_q + 4'd1;
          end else begin
            byteIdx_d = byteIdx_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Setting the sticky flag takes priority over a simultaneous clear.
    overrun_d = overrun_q;
    if (clear_overrun) begin
      overrun_d = 1'b0;
    end
    if (rise && sending && !(handshake && lastByte)) begin
      overrun_d = 1'b1;
    end
  end

  // Output logic: everything is decoded from registered state only, so the
  // stream holds steady under back-pressure and out_ready has no
  // combinational path to the outputs.
  always_comb begin
    out_if.out_valid = sending;
    out_if.out_data  = 8'd0;
    if (sending) begin
      case (byteIdx_q)
        2'd0:    out_if.out_data = curElem[7:0];
        2'd1:    out_if.out_data = curElem[15:8];
        2'd2:    out_if.out_data = curElem[23:16];
        default: out_if.out_data = 8'd0;
      endcase
    end
    out_if.out_last = sending && lastByte;
    busy            = sending;
    frame_done      = frameDone_q;
    overrun         = overrun_q;
  end

endmodule

// File: tb/tb_matrix_result_reader.sv
// ---------------------------------------------------------------------------
// tb_matrix_result_reader
//
// Self-checking bench for matrix_result_reader. Expected bytes are pushed to
// a scoreboard queue when a frame is started and popped by a byte monitor on
// every accepted byte. Each scenario task drives its own stimulus and checks
// the scenario-specific timing and status behaviour.
// ---------------------------------------------------------------------------
module tb_matrix_result_reader;

  typedef logic [17:0] frame_t [9];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        done_in = 1'b0;
  logic        clear_overrun = 1'b0;
  logic [17:0] cIn [9];
  logic        busy;
  logic        frame_done;
  logic        overrun;

  matrix_result_reader_if busIf ();

  matrix_result_reader dut (
    .clk           (clk),
    .reset         (reset),
    .done_in       (done_in),
    .C0            (cIn[0]),
    .C1            (cIn[1]),
    .C2            (cIn[2]),
    .C3            (cIn[3]),
    .C4            (cIn[4]),
    .C5            (cIn[5]),
    .C6            (cIn[6]),
    .C7            (cIn[7]),
    .C8            (cIn[8]),
    .out_if        (busIf),
    .clear_overrun (clear_overrun),
    .busy          (busy),
    .frame_done    (frame_done),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  logic [8:0] sbQ [$];
  logic [8:0] expB;
  logic [8:0] prevBus;
  logic       prevStall = 1'b0;
  int checks = 0;
  int errors = 0;
  int fdCount = 0;
  int byteCount = 0;
  int busyCycles = 0;
  int cycleCnt = 0;
  int lastCycle = 0;
  int fdCycle = 0;

  // Byte monitor: scoreboard comparison on every accepted byte plus a
  // stability check on the cycle following every stalled byte.
  always @(negedge clk) begin
    cycleCnt++;
    if (busy) busyCycles++;
    if (frame_done) begin
      fdCount++;
      fdCycle = cycleCnt;
    end
    if (reset && prevStall && busIf.out_valid) begin
      checks++;
      if ({busIf.out_last, busIf.out_data} !== prevBus) begin
        errors++;
        $display("[TB] FAIL hold_stable: got last=%b data=%h, required last=%b data=%h",
                 busIf.out_last, busIf.out_data, prevBus[8], prevBus[7:0]);
      end
    end
    if (reset && busIf.out_valid && busIf.out_ready) begin
      checks++;
      byteCount++;
      if (busIf.out_last) lastCycle = cycleCnt;
      if (sbQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL byte_extra: got last=%b data=%h, required no byte",
                 busIf.out_last, busIf.out_data);
      end else begin
        expB = sbQ.pop_front();
        if ({busIf.out_last, busIf.out_data} !== expB) begin
          errors++;
          $display("[TB] FAIL byte_value: got last=%b data=%h, required last=%b data=%h",
                   busIf.out_last, busIf.out_data, expB[8], expB[7:0]);
        end
      end
    end
    prevStall = reset && busIf.out_valid && !busIf.out_ready;
    prevBus   = {busIf.out_last, busIf.out_data};
  end

  task automatic setC(input frame_t f);
    for (int i = 0; i < 9; i++) cIn[i] = f[i];
  endtask

  task automatic pushFrame(input frame_t f);
    for (int e = 0; e < 9; e++) begin
      for (int b = 0; b < 3; b++) begin
        logic [7:0] v;
        case (b)
          0:       v = f[e][7:0];
          1:       v = f[e][15:8];
          default: v = {6'b0, f[e][17:16]};
        endcase
        sbQ.push_back({(e == 8 && b == 2), v});
      end
    end
  endtask

  // Leaves the bench one step after the edge on which the rise was sampled.
  task automatic driveRise();
    @(posedge clk); #1 done_in = 1'b1;
    @(posedge clk); #1 done_in = 1'b0;
  endtask

  task automatic waitFd(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (fdCount >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    frame_t f;
    bit ok;
    int fd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busIf.out_data, busIf.out_valid, busIf.out_last, busy, frame_done, overrun} !== 13'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got data=%h valid=%b last=%b busy=%b fd=%b ovr=%b, required all 0",
               busIf.out_data, busIf.out_valid, busIf.out_last, busy, frame_done, overrun);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || busIf.out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got busy=%b valid=%b, required 0 0", busy, busIf.out_valid);
    end
    // done_in already high when reset releases must count as a rise
    for (int i = 0; i < 9; i++) f[i] = 18'h2_0000 | 18'(i * 7);
    setC(f);
    @(posedge clk); #1 reset = 1'b0; done_in = 1'b1;
    busIf.out_ready = 1'b1;
    pushFrame(f);
    fd0 = fdCount;
    @(posedge clk); #1 reset = 1'b1;
    waitFd(fd0 + 1, 100, ok);
    checks++;
    if (!ok || sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_release_rise: got frame_done=%0d left=%0d, required frame_done=1 left=0",
               ok, sbQ.size());
    end
    @(posedge clk); #1 done_in = 1'b0;
  endtask

  task automatic test_basic();
    frame_t f;
    bit ok;
    int fd0, b0;
    f = '{18'h3FFFF, 18'h12345, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h0};
    setC(f);
    pushFrame(f);
    busIf.out_ready = 1'b1;
    fd0 = fdCount;
    b0 = byteCount;
    busyCycles = 0;
    driveRise();
    @(negedge clk);
    checks++;
    if (busIf.out_valid !== 1'b1 || busIf.out_data !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL basic_latency: got valid=%b data=%h, required valid=1 data=ff",
               busIf.out_valid, busIf.out_data);
    end
    waitFd(fd0 + 1, 100, ok);
    checks++;
    if (!ok || byteCount - b0 != 27 || sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL basic_frame: got done=%0d bytes=%0d left=%0d, required done=1 bytes=27 left=0",
               ok, byteCount - b0, sbQ.size());
    end
    checks++;
    if (busyCycles != 27) begin
      errors++;
      $display("[TB] FAIL basic_busy: got %0d busy cycles, required 27", busyCycles);
    end
    checks++;
    if (fdCycle != lastCycle + 1) begin
      errors++;
      $display("[TB] FAIL basic_fd_timing: got fd at cycle %0d, required %0d", fdCycle, lastCycle + 1);
    end
  endtask

  task automatic test_backpressure();
    frame_t f;
    bit ok;
    int fd0, b0;
    for (int i = 0; i < 9; i++) f[i] = 18'h1_0000 + 18'(i);
    setC(f);
    pushFrame(f);
    fd0 = fdCount;
    b0 = byteCount;
    busIf.out_ready = 1'b0;
    driveRise();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1 busIf.out_ready = ($urandom_range(0, 99) < 30);
      if (fdCount >= fd0 + 1) begin
        ok = 1'b1;
        break;
      end
    end
    busIf.out_ready = 1'b1;
    checks++;
    if (!ok || byteCount - b0 != 27 || sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL backpressure_frame: got done=%0d bytes=%0d left=%0d, required done=1 bytes=27 left=0",
               ok, byteCount - b0, sbQ.size());
    end
  endtask

  task automatic test_overrun();
    frame_t a, b;
    bit ok;
    int fd0, b0;
    for (int i = 0; i < 9; i++) begin
      a[i] = 18'h0ABCD ^ (18'(i) << 4);
      b[i] = ~a[i];
    end
    busIf.out_ready = 1'b1;
    setC(a);
    pushFrame(a);
    fd0 = fdCount;
    b0 = byteCount;
    driveRise();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (byteCount - b0 >= 10) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1 setC(b); done_in = 1'b1;
    @(posedge clk); #1 done_in = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_set: got reached=%0d overrun=%b, required 1 1", ok, overrun);
    end
    waitFd(fd0 + 1, 100, ok);
    checks++;
    if (!ok || sbQ.size() != 0 || byteCount - b0 != 27 || overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_stream: got done=%0d bytes=%0d left=%0d overrun=%b, required 1 27 0 1",
               ok, byteCount - b0, sbQ.size(), overrun);
    end
    @(posedge clk); #1 clear_overrun = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_clear: got %b, required 0", overrun);
    end
    // Set and clear on the same edge: set must win
    setC(a);
    pushFrame(a);
    fd0 = fdCount;
    driveRise();
    repeat (5) @(posedge clk);
    #1 setC(b); done_in = 1'b1; clear_overrun = 1'b1;
    @(posedge clk); #1 done_in = 1'b0; clear_overrun = 1'b0;
    @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_set_wins: got %b, required 1", overrun);
    end
    waitFd(fd0 + 1, 100, ok);
    checks++;
    if (!ok || sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL overrun_stream2: got done=%0d left=%0d, required 1 0", ok, sbQ.size());
    end
    @(posedge clk); #1 clear_overrun = 1'b1;
    @(posedge clk); #1 clear_overrun = 1'b0;
  endtask

  task automatic test_back_to_back();
    frame_t a, b;
    bit ok;
    int fd0, b0;
    for (int i = 0; i < 9; i++) begin
      a[i] = 18'h3_0000 | 18'(i * 18'h123);
      b[i] = 18'h0_5A5A + 18'(i * 18'h1011);
    end
    busIf.out_ready = 1'b1;
    setC(a);
    pushFrame(a);
    fd0 = fdCount;
    b0 = byteCount;
    busyCycles = 0;
    driveRise();
    // Byte 27 of frame A is accepted 27 edges after the capture edge
    repeat (26) @(posedge clk);
    #1 setC(b); done_in = 1'b1;
    pushFrame(b);
    @(posedge clk); #1 done_in = 1'b0;
    waitFd(fd0 + 2, 150, ok);
    checks++;
    if (!ok || byteCount - b0 != 54 || sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_frames: got done=%0d bytes=%0d left=%0d, required 1 54 0",
               ok, byteCount - b0, sbQ.size());
    end
    checks++;
    if (busyCycles != 54 || fdCount - fd0 != 2) begin
      errors++;
      $display("[TB] FAIL b2b_continuous: got busy=%0d fd=%0d, required busy=54 fd=2",
               busyCycles, fdCount - fd0);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_overrun: got %b, required 0", overrun);
    end
  endtask

  task automatic test_reset_mid_stream();
    frame_t f;
    bit ok;
    bit stayed;
    int fd0, b0;
    for (int i = 0; i < 9; i++) f[i] = 18'h1_FFFF - 18'(i * 18'h321);
    busIf.out_ready = 1'b1;
    setC(f);
    pushFrame(f);
    b0 = byteCount;
    driveRise();
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (byteCount - b0 >= 5) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    #1;
    checks++;
    if (!ok || {busIf.out_data, busIf.out_valid, busIf.out_last, busy, frame_done, overrun} !== 13'b0) begin
      errors++;
      $display("[TB] FAIL reset_abort: got reached=%0d data=%h valid=%b last=%b busy=%b fd=%b ovr=%b, required 1 and all 0",
               ok, busIf.out_data, busIf.out_valid, busIf.out_last, busy, frame_done, overrun);
    end
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    stayed = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || busIf.out_valid !== 1'b0) stayed = 1'b0;
    end
    checks++;
    if (!stayed) begin
      errors++;
      $display("[TB] FAIL reset_stay_idle: got busy/valid active after release, required idle");
    end
    pushFrame(f);
    fd0 = fdCount;
    driveRise();
    waitFd(fd0 + 1, 100, ok);
    checks++;
    if (!ok || sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL reset_restart: got done=%0d left=%0d, required 1 0", ok, sbQ.size());
    end
  endtask

  task automatic test_level_hold();
    frame_t a, b;
    bit ok;
    int fd0, b0;
    for (int i = 0; i < 9; i++) begin
      a[i] = 18'h2_4680 + 18'(i);
      b[i] = 18'h1_3579 ^ 18'(i << 8);
    end
    busIf.out_ready = 1'b1;
    setC(a);
    pushFrame(a);
    fd0 = fdCount;
    b0 = byteCount;
    @(posedge clk); #1 done_in = 1'b1;
    repeat (100) @(posedge clk);
    #1 done_in = 1'b0;
    checks++;
    if (fdCount - fd0 != 1 || byteCount - b0 != 27 || sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL level_single: got fd=%0d bytes=%0d left=%0d, required 1 27 0",
               fdCount - fd0, byteCount - b0, sbQ.size());
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL level_overrun: got %b, required 0", overrun);
    end
    setC(b);
    pushFrame(b);
    driveRise();
    waitFd(fd0 + 2, 100, ok);
    checks++;
    if (!ok || sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL level_second: got done=%0d left=%0d, required 1 0", ok, sbQ.size());
    end
  endtask

  initial begin
    frame_t z;
    for (int i = 0; i < 9; i++) z[i] = 18'h0;
    setC(z);
    busIf.out_ready = 1'b0;
    $display("[TB] starting matrix_result_reader bench");
    test_reset();
    test_basic();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid_stream();
    test_level_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
